psl_cmd_responder: RTL and testbench

- Synthesizable PSL-side emulator for the CAPI command/response interface. It is the responder end of the AFU's ah_c* command bus.
- Accepts AFU commands and checks them. Each command's tag is returned on the ha_r* response bus after a programmable minimum latency, in order.
- Advertises command room and returns one response credit per response.
- Used in loopback builds and sim benches that have no real PSL.

---
 rtl/capi_pkg.sv | 22 ++
 rtl/cmd_tag_fifo.sv | 65 ++++++
 rtl/psl_cmd_responder.sv | 142 ++++++++++++++
 tb/tb_psl_cmd_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/capi_pkg.sv
// Shared CAPI command/response definitions for the PSL-side responder.
// Response codes, the queued response entry and the parity helper.
package capi_pkg;

    localparam int TS_W_MAX = 32;

    localparam logic [0:7] RSP_DONE   = 8'h00;
    localparam logic [0:7] RSP_AERROR = 8'h01;
    localparam logic [0:7] RSP_FAILED = 8'h08;

    // ts is sized for the widest supported counter; narrower builds zero-extend.
    typedef struct packed {
        logic [0:7]          tag;
        logic [0:7]          code;
        logic [TS_W_MAX-1:0] ts;
    } rsp_entry_t;

    function automatic logic odd_parity(input logic [15:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/cmd_tag_fifo.sv
// Synchronous FIFO of pending response entries.
// A push is accepted while full only when a pop happens in the same cycle.
module cmd_tag_fifo
    import capi_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  rsp_entry_t   entry_i,
    input  logic         pop_i,
    output rsp_entry_t   entry_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);

    rsp_entry_t mem_q [DEPTH];

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign entry_o = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= entry_i;
    end

endmodule

// File: rtl/psl_cmd_responder.sv
// PSL-side responder for the CAPI ah_c*/ha_r* buses: checks each AFU
// command and returns its tag in order after a minimum latency.
module psl_cmd_responder
    import capi_pkg::*;
#(
    parameter int CROOM       = 64,
    parameter int RSP_LATENCY = 4,
    parameter int TS_W        = 16
) (
    input  logic        ha_pclock,
    input  logic        rstn,
    input  logic        parity_en,
    input  logic        ah_cvalid,
    input  logic [0:7]  ah_ctag,
    input  logic        ah_ctagpar,
    input  logic [0:12] ah_com,
    input  logic        ah_compar,
    input  logic [0:63] ah_cea,
    input  logic [0:11] ah_csize,
    output logic [0:7]  ha_croom,
    output logic        ha_rvalid,
    output logic [0:7]  ha_rtag,
    output logic        ha_rtagpar,
    output logic [0:7]  ha_response,
    output logic [0:8]  ha_rcredits,
    output logic [0:1]  ha_rcachestate,
    output logic [0:12] ha_rcachepos,
    output logic        overflow_err
);

    localparam int AW = $clog2(CROOM);
    localparam logic [TS_W_MAX-1:0] TS_MASK =
        TS_W_MAX'((64'd1 << TS_W) - 64'd1);

    logic [TS_W-1:0] ts_q, ts_d;
    logic            rvalid_q, rvalid_d;
    logic [0:7]      rtag_q, rtag_d;
    logic            rtagpar_q, rtagpar_d;
    logic [0:7]      rcode_q, rcode_d;
    logic            ovf_q, ovf_d;

    logic [11:0]     size_m1;
    logic            par_bad;
    logic            size_ok;
    logic            misalign;
    logic [0:7]      cmd_code;

    rsp_entry_t          new_entry;
    rsp_entry_t          head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW:0]         unused_count;
    logic                unused_cea;
    logic [TS_W_MAX-1:0] age;
    logic                issue;
    logic                push;

    assign unused_cea = ^ah_cea[0:55];

    always_comb begin
        size_m1  = ah_csize - 12'd1;
        par_bad  = parity_en &&
                   ((ah_ctagpar != odd_parity(16'(ah_ctag))) ||
                    (ah_compar  != odd_parity(16'(ah_com))));
        size_ok  = (ah_csize != '0) &&
                   ((ah_csize & size_m1) == '0) &&
                   (ah_csize <= 12'd128);
        misalign = |(ah_cea[56:63] & size_m1[7:0]);
        if (par_bad)
            cmd_code = RSP_FAILED;
        else if (!size_ok || misalign)
            cmd_code = RSP_AERROR;
        else
            cmd_code = RSP_DONE;
    end

    assign new_entry.tag  = ah_ctag;
    assign new_entry.code = cmd_code;
    assign new_entry.ts   = TS_W_MAX'(ts_q);

    // Modular age, so a counter wrap between push and issue is harmless.
    assign age   = (TS_W_MAX'(ts_q) - head.ts) & TS_MASK;
    assign issue = !fifo_empty && (age >= TS_W_MAX'(RSP_LATENCY));
    assign push  = ah_cvalid && (!fifo_full || issue);

    cmd_tag_fifo #(
        .DEPTH (CROOM)
    ) u_fifo (
        .clk     (ha_pclock),
        .rst_n   (rstn),
        .push_i  (push),
        .entry_i (new_entry),
        .pop_i   (issue),
        .entry_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_count)
    );

    always_comb begin
        ts_d      = ts_q + TS_W'(1);
        rvalid_d  = issue;
        rtag_d    = rtag_q;
        rtagpar_d = rtagpar_q;
        rcode_d   = rcode_q;
        ovf_d     = ovf_q | (ah_cvalid && fifo_full && !issue);
        if (issue) begin
            rtag_d    = head.tag;
            rtagpar_d = odd_parity(16'(head.tag));
            rcode_d   = head.code;
        end
    end

    always_ff @(posedge ha_pclock or negedge rstn) begin
        if (!rstn) begin
            ts_q      <= '0;
            rvalid_q  <= 1'b0;
            rtag_q    <= '0;
            rtagpar_q <= 1'b1;
            rcode_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            ts_q      <= ts_d;
            rvalid_q  <= rvalid_d;
            rtag_q    <= rtag_d;
            rtagpar_q <= rtagpar_d;
            rcode_q   <= rcode_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ha_croom       = 8'(CROOM);
    assign ha_rvalid      = rvalid_q;
    assign ha_rtag        = rtag_q;
    assign ha_rtagpar     = rtagpar_q;
    assign ha_response    = rcode_q;
    assign ha_rcredits    = {8'd0, rvalid_q};
    assign ha_rcachestate = '0;
    assign ha_rcachepos   = '0;
    assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_psl_cmd_responder.sv
// Scoreboard bench for psl_cmd_responder: three instances cover the
// nominal latency, a stalled fill/overflow case and a narrow wrapping counter.
module tb_psl_cmd_responder;

    localparam logic [12:0] COM = 13'h0A00;

    typedef struct {
        logic [7:0] tag;
        logic [7:0] code;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic parity_en;
    logic cv_m, cv_s, cv_w;
    logic [0:7]  ah_ctag;
    logic        ah_ctagpar;
    logic [0:12] ah_com;
    logic        ah_compar;
    logic [0:63] ah_cea;
    logic [0:11] ah_csize;

    logic [0:7]  m_croom, s_croom, w_croom;
    logic        m_rvalid, s_rvalid, w_rvalid;
    logic [0:7]  m_rtag, s_rtag, w_rtag;
    logic        m_rtagpar, s_rtagpar, w_rtagpar;
    logic [0:7]  m_resp, s_resp, w_resp;
    logic [0:8]  m_rcred, s_rcred, w_rcred;
    logic [0:1]  m_cst, s_cst, w_cst;
    logic [0:12] m_cpos, s_cpos, w_cpos;
    logic        m_ovf, s_ovf, w_ovf;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   last_n;
    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_w[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psl_cmd_responder #(.CROOM(64), .RSP_LATENCY(4), .TS_W(16)) u_main (
        .ha_pclock(clk), .rstn(rstn), .parity_en(parity_en),
        .ah_cvalid(cv_m), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar),
        .ah_com(ah_com), .ah_compar(ah_compar), .ah_cea(ah_cea),
        .ah_csize(ah_csize), .ha_croom(m_croom), .ha_rvalid(m_rvalid),
        .ha_rtag(m_rtag), .ha_rtagpar(m_rtagpar), .ha_response(m_resp),
        .ha_rcredits(m_rcred), .ha_rcachestate(m_cst),
        .ha_rcachepos(m_cpos), .overflow_err(m_ovf));

    psl_cmd_responder #(.CROOM(64), .RSP_LATENCY(200), .TS_W(16)) u_slow (
        .ha_pclock(clk), .rstn(rstn), .parity_en(parity_en),
        .ah_cvalid(cv_s), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar),
        .ah_com(ah_com), .ah_compar(ah_compar), .ah_cea(ah_cea),
        .ah_csize(ah_csize), .ha_croom(s_croom), .ha_rvalid(s_rvalid),
        .ha_rtag(s_rtag), .ha_rtagpar(s_rtagpar), .ha_response(s_resp),
        .ha_rcredits(s_rcred), .ha_rcachestate(s_cst),
        .ha_rcachepos(s_cpos), .overflow_err(s_ovf));

    psl_cmd_responder #(.CROOM(64), .RSP_LATENCY(3), .TS_W(4)) u_wrap (
        .ha_pclock(clk), .rstn(rstn), .parity_en(parity_en),
        .ah_cvalid(cv_w), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar),
        .ah_com(ah_com), .ah_compar(ah_compar), .ah_cea(ah_cea),
        .ah_csize(ah_csize), .ha_croom(w_croom), .ha_rvalid(w_rvalid),
        .ha_rtag(w_rtag), .ha_rtagpar(w_rtagpar), .ha_response(w_resp),
        .ha_rcredits(w_rcred), .ha_rcachestate(w_cst),
        .ha_rcachepos(w_cpos), .overflow_err(w_ovf));

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 4 : (d == 1) ? 200 : 3;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q_m.size() : (d == 1) ? q_s.size() : q_w.size();
    endfunction

    function automatic logic [7:0] model(input logic pen,
        input logic [7:0] tag, input logic tp, input logic [12:0] com,
        input logic cp, input logic [63:0] cea, input logic [11:0] sz);
        if (pen && ((tp != ~^tag) || (cp != ~^com)))
            return 8'h08;
        if (!(sz inside {12'd1, 12'd2, 12'd4, 12'd8, 12'd16, 12'd32,
                         12'd64, 12'd128}))
            return 8'h01;
        if ((cea[7:0] & (sz[7:0] - 8'd1)) != 8'd0)
            return 8'h01;
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cv_m = 1'b0;
        cv_s = 1'b0;
        cv_w = 1'b0;
    endtask

    task automatic send(input int d, input logic pen, input logic [7:0] tag,
        input logic tpflip, input logic cpflip, input logic [63:0] cea,
        input logic [11:0] sz, input bit keep);
        exp_t e;
        tick();
        parity_en  = pen;
        ah_ctag    = tag;
        ah_ctagpar = (~^tag) ^ tpflip;
        ah_com     = COM;
        ah_compar  = (~^COM) ^ cpflip;
        ah_cea     = cea;
        ah_csize   = sz;
        last_n     = cyc + 1;
        e.tag  = tag;
        e.code = model(pen, tag, ah_ctagpar, COM, ah_compar, cea, sz);
        e.cyc  = last_n + lat(d);
        case (d)
            0: begin cv_m = 1'b1; if (keep) q_m.push_back(e); end
            1: begin cv_s = 1'b1; if (keep) q_s.push_back(e); end
            default: begin cv_w = 1'b1; if (keep) q_w.push_back(e); end
        endcase
    endtask

    task automatic drain(input int d, input int maxc);
        int n;
        n = qsize(d);
        for (int i = 0; i < maxc && n > 0; i++) begin
            tick();
            n = qsize(d);
        end
        chk($sformatf("drain_d%0d", d), 64'(n), 64'd0);
    endtask

    task automatic mon(input int d, input logic v, input logic [7:0] tg,
        input logic tp, input logic [7:0] rs, input logic [8:0] cr);
        exp_t e;
        if (!v) begin
            if (d == 0) chk("credits_idle", 64'(cr), 64'd0);
            return;
        end
        if (qsize(d) == 0) begin
            chk($sformatf("unexpected_rsp_d%0d", d), 64'(v), 64'd0);
            return;
        end
        case (d)
            0: e = q_m.pop_front();
            1: e = q_s.pop_front();
            default: e = q_w.pop_front();
        endcase
        chk($sformatf("rtag_d%0d", d), 64'(tg), 64'(e.tag));
        chk($sformatf("rcode_d%0d_t%0h", d, e.tag), 64'(rs), 64'(e.code));
        chk($sformatf("rtagpar_d%0d", d), 64'(tp), 64'(~^e.tag));
        chk($sformatf("rcredits_d%0d", d), 64'(cr), 64'd1);
        chk($sformatf("latency_d%0d_t%0h", d, e.tag), 64'(cyc), 64'(e.cyc));
    endtask

    always @(negedge clk) mon(0, m_rvalid, m_rtag, m_rtagpar, m_resp, m_rcred);
    always @(negedge clk) mon(1, s_rvalid, s_rtag, s_rtagpar, s_resp, s_rcred);
    always @(negedge clk) mon(2, w_rvalid, w_rtag, w_rtagpar, w_resp, w_rcred);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n0;
        rstn = 1'b0;
        parity_en = 1'b1;
        cv_m = 1'b0; cv_s = 1'b0; cv_w = 1'b0;
        ah_ctag = '0; ah_ctagpar = 1'b1; ah_com = COM; ah_compar = ~^COM;
        ah_cea = '0; ah_csize = 12'd1;
        repeat (3) tick();
        chk("croom_in_reset", 64'(m_croom), 64'd64);
        rstn = 1'b1;
        tick();
        chk("rst_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_rtag", 64'(m_rtag), 64'd0);
        chk("rst_rtagpar", 64'(m_rtagpar), 64'd1);
        chk("rst_response", 64'(m_resp), 64'd0);
        chk("rst_rcredits", 64'(m_rcred), 64'd0);
        chk("rst_overflow", 64'(m_ovf), 64'd0);
        chk("rst_cache", 64'({m_cst, m_cpos}), 64'd0);
        repeat (5) tick();

        send(0, 1, 8'h05, 0, 0, 64'h1000, 12'd128, 1);
        drain(0, 20);

        send(0, 1, 8'h01, 0, 0, 64'h2000, 12'd64, 1);
        send(0, 1, 8'h02, 0, 0, 64'h2040, 12'd64, 1);
        send(0, 1, 8'h03, 0, 0, 64'h2080, 12'd64, 1);
        drain(0, 20);

        send(0, 1, 8'h10, 0, 0, 64'h1040, 12'd128, 1);
        send(0, 1, 8'h11, 0, 0, 64'h1000, 12'd3, 1);
        send(0, 1, 8'h12, 0, 0, 64'h1040, 12'd64, 1);
        send(0, 1, 8'h13, 0, 0, 64'h1000, 12'd0, 1);
        send(0, 1, 8'h14, 0, 0, 64'h1000, 12'd256, 1);
        send(0, 1, 8'h15, 0, 0, 64'h1001, 12'd1, 1);
        drain(0, 30);

        send(0, 1, 8'h20, 1, 0, 64'h1000, 12'd128, 1);
        send(0, 0, 8'h21, 1, 0, 64'h1000, 12'd128, 1);
        send(0, 1, 8'h22, 0, 1, 64'h1000, 12'd128, 1);
        send(0, 1, 8'h23, 1, 0, 64'h1000, 12'd3, 1);
        drain(0, 30);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(2, 1, 8'(8'h40 + i), 0, 0, 64'h0,
                 (i % 5 == 0) ? 12'd3 : 12'd64, 1);
        end
        drain(2, 30);

        for (int i = 0; i < 64; i++) begin
            send(1, 1, 8'(i), 0, 0, 64'h4000 + 64'(i) * 64'd128, 12'd128, 1);
            if (i == 0) n0 = last_n;
        end
        tick();
        chk("ovf_before_full", 64'(s_ovf), 64'd0);
        send(1, 1, 8'hFF, 0, 0, 64'h0, 12'd128, 0);
        tick();
        chk("ovf_after_drop", 64'(s_ovf), 64'd1);
        while (cyc < n0 + 198) tick();
        send(1, 1, 8'hAA, 0, 0, 64'h8000, 12'd128, 1);
        chk("push_pop_when_full_cycle", 64'(last_n), 64'(n0 + 200));
        drain(1, 500);
        chk("ovf_sticky", 64'(s_ovf), 64'd1);

        for (int i = 0; i < 10; i++)
            send(0, 1, 8'(8'h60 + i), 0, 0, 64'h1000, 12'd128, 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = m_rvalid;
        end
        chk("rvalid_before_reset", 64'(seen), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_rvalid", 64'(m_rvalid), 64'd0);
        chk("async_rst_rcredits", 64'(m_rcred), 64'd0);
        chk("ovf_cleared", 64'(s_ovf), 64'd0);
        q_m.delete();
        q_s.delete();
        q_w.delete();
        repeat (2) tick();
        rstn = 1'b1;
        repeat (40) tick();
        send(0, 1, 8'h77, 0, 0, 64'h3000, 12'd32, 1);
        drain(0, 20);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
